// File: rtl/program_rom_pkg.sv
// Shared types and widths for the program ROM arbiter.
package program_rom_pkg;

    localparam int ROM_ADDR_W = 15;
    localparam int ROM_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef enum logic {
        OWNER_CPU = 1'b0,
        OWNER_DBG = 1'b1
    } owner_t;

endpackage

// File: rtl/rom_grant_select.sv
// Winner selection between CPU fetch and debug reads, with a CPU burst
// counter that forces a debug grant once the CPU has been favoured too long.
module rom_grant_select
    import program_rom_pkg::*;
#(
    parameter int MAX_CPU_BURST = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic decide_i,
    input  logic cpu_req_i,
    input  logic dbg_req_i,
    output logic grant_o,
    output logic dbg_win_o
);

    localparam logic [3:0] BURST_LIMIT = 4'(MAX_CPU_BURST);

    logic [3:0] burst_q;
    logic [3:0] burst_d;
    logic       dbg_win;

    always_comb begin
        dbg_win = dbg_req_i && (!cpu_req_i || (burst_q >= BURST_LIMIT));
        burst_d = burst_q;
        if (decide_i) begin
            // Only CPU grants that keep a waiting debug request out count.
            if (!dbg_req_i || dbg_win) begin
                burst_d = '0;
            end else if (cpu_req_i && (burst_q < BURST_LIMIT)) begin
                burst_d = burst_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            burst_q <= '0;
        end else begin
            burst_q <= burst_d;
        end
    end

    assign grant_o   = cpu_req_i | dbg_req_i;
    assign dbg_win_o = dbg_win;

endmodule

// File: rtl/program_rom_arbiter.sv
// Shares the single-port program ROM between CPU fetch and the debug port,
// sequencing each access through IDLE -> BUSY -> RESP.
module program_rom_arbiter
    import program_rom_pkg::*;
#(
    parameter int ADDR_W        = ROM_ADDR_W,
    parameter int DATA_W        = ROM_DATA_W,
    parameter int READ_LATENCY  = 1,
    parameter int MAX_CPU_BURST = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpuReq,
    input  logic [ADDR_W-1:0] cpuAddr,
    output logic              cpuValid,
    output logic [DATA_W-1:0] cpuData,
    input  logic              dbgReq,
    input  logic [ADDR_W-1:0] dbgAddr,
    output logic              dbgValid,
    output logic [DATA_W-1:0] dbgData,
    output logic              romChipSelect,
    output logic [ADDR_W-1:0] romAddress,
    input  logic [DATA_W-1:0] romData
);

    localparam logic [2:0] LAT_LAST = 3'(READ_LATENCY);

    state_t            state_q, state_d;
    owner_t            owner_q, owner_d;
    logic [2:0]        lat_cnt_q, lat_cnt_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic              rom_cs_q, rom_cs_d;
    logic [DATA_W-1:0] cpu_data_q, cpu_data_d;
    logic [DATA_W-1:0] dbg_data_q, dbg_data_d;
    logic              cpu_valid_q, cpu_valid_d;
    logic              dbg_valid_q, dbg_valid_d;
    logic              grant;
    logic              dbg_win;

    rom_grant_select #(
        .MAX_CPU_BURST(MAX_CPU_BURST)
    ) u_grant (
        .clk       (clk),
        .reset     (reset),
        .decide_i  (state_q == IDLE),
        .cpu_req_i (cpuReq),
        .dbg_req_i (dbgReq),
        .grant_o   (grant),
        .dbg_win_o (dbg_win)
    );

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        lat_cnt_d   = lat_cnt_q;
        rom_addr_d  = rom_addr_q;
        rom_cs_d    = rom_cs_q;
        cpu_data_d  = cpu_data_q;
        dbg_data_d  = dbg_data_q;
        cpu_valid_d = 1'b0;
        dbg_valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant) begin
                    rom_addr_d = dbg_win ? dbgAddr : cpuAddr;
                    owner_d    = dbg_win ? OWNER_DBG : OWNER_CPU;
                    lat_cnt_d  = '0;
                    rom_cs_d   = 1'b1;
                    state_d    = BUSY;
                end
            end
            BUSY: begin
                lat_cnt_d = lat_cnt_q + 3'd1;
                // The bus is only trusted on this one cycle; elsewhere it floats.
                if (lat_cnt_q == LAT_LAST) begin
                    rom_cs_d = 1'b0;
                    state_d  = RESP;
                    if (owner_q == OWNER_DBG) begin
                        dbg_data_d  = romData;
                        dbg_valid_d = 1'b1;
                    end else begin
                        cpu_data_d  = romData;
                        cpu_valid_d = 1'b1;
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            owner_q     <= OWNER_CPU;
            lat_cnt_q   <= '0;
            rom_addr_q  <= '0;
            rom_cs_q    <= 1'b0;
            cpu_data_q  <= '0;
            dbg_data_q  <= '0;
            cpu_valid_q <= 1'b0;
            dbg_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            lat_cnt_q   <= lat_cnt_d;
            rom_addr_q  <= rom_addr_d;
            rom_cs_q    <= rom_cs_d;
            cpu_data_q  <= cpu_data_d;
            dbg_data_q  <= dbg_data_d;
            cpu_valid_q <= cpu_valid_d;
            dbg_valid_q <= dbg_valid_d;
        end
    end

    assign cpuValid      = cpu_valid_q;
    assign cpuData       = cpu_data_q;
    assign dbgValid      = dbg_valid_q;
    assign dbgData       = dbg_data_q;
    assign romChipSelect = rom_cs_q;
    assign romAddress    = rom_addr_q;

endmodule

// File: tb/tb_program_rom_arbiter.sv
// Bench for program_rom_arbiter: directed phases plus random traffic checked
// against a timestamp-based model of grants, latency and starvation rules.
module tb_program_rom_arbiter;

    localparam int L1   = 1;
    localparam int MAXB = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpuReq, dbgReq, cpuValid, dbgValid, romChipSelect;
    logic [14:0] cpuAddr, dbgAddr, romAddress;
    logic [7:0]  cpuData, dbgData, romData;

    logic        cpuReq3, dbgReq3, cpuValid3, dbgValid3, romChipSelect3;
    logic [14:0] cpuAddr3, dbgAddr3, romAddress3;
    logic [7:0]  cpuData3, dbgData3, romData3;

    logic [7:0]  mem [0:32767];

    always #5 clk = ~clk;

    program_rom_arbiter #(.READ_LATENCY(1), .MAX_CPU_BURST(MAXB)) dut (
        .clk(clk), .reset(reset),
        .cpuReq(cpuReq), .cpuAddr(cpuAddr), .cpuValid(cpuValid), .cpuData(cpuData),
        .dbgReq(dbgReq), .dbgAddr(dbgAddr), .dbgValid(dbgValid), .dbgData(dbgData),
        .romChipSelect(romChipSelect), .romAddress(romAddress), .romData(romData)
    );

    program_rom_arbiter #(.READ_LATENCY(3), .MAX_CPU_BURST(MAXB)) dut3 (
        .clk(clk), .reset(reset),
        .cpuReq(cpuReq3), .cpuAddr(cpuAddr3), .cpuValid(cpuValid3), .cpuData(cpuData3),
        .dbgReq(dbgReq3), .dbgAddr(dbgAddr3), .dbgValid(dbgValid3), .dbgData(dbgData3),
        .romChipSelect(romChipSelect3), .romAddress(romAddress3), .romData(romData3)
    );

    // ROM models: data appears READ_LATENCY edges after the address is sampled
    // under chip select; any other time the bus carries junk.
    logic [7:0] dpipe = 8'h00;
    logic       vpipe = 1'b0;
    always @(posedge clk) begin
        dpipe <= mem[romAddress];
        vpipe <= romChipSelect;
    end
    assign romData = (romChipSelect && vpipe) ? dpipe : 8'hEE;

    logic [7:0] dp3 [3];
    logic [2:0] vp3 = 3'b000;
    always @(posedge clk) begin
        dp3[0] <= mem[romAddress3];
        dp3[1] <= dp3[0];
        dp3[2] <= dp3[1];
        vp3    <= {vp3[1:0], romChipSelect3};
    end
    assign romData3 = (romChipSelect3 && vp3[2]) ? dp3[2] : 8'hEE;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    // Reference model state
    bit          m_active = 1'b0;
    bit          m_own_dbg = 1'b0;
    int          grant_t = 0;
    int          t_free = 0;
    int          burst = 0;
    logic [14:0] m_acc_addr = '0;
    logic [14:0] m_rom_addr = '0;
    logic [7:0]  m_cpu_data = '0;
    logic [7:0]  m_dbg_data = '0;

    // Observation bookkeeping
    bit cv_last = 0, cv_prev = 0, dv_last = 0, dv_prev = 0, dv3_last = 0, dv3_prev = 0;
    int cv_count = 0, dv_count = 0, cv_cyc = -1, dv_cyc = -1;
    int dv3_count = 0, dv3_cyc = -1, cs3_count = 0, cv3_count = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic check_outputs();
        int  done_t;
        bit  exp_cs, exp_cv, exp_dv;
        done_t = grant_t + 2 + L1;
        if (m_active && cyc == done_t) begin
            if (m_own_dbg) m_dbg_data = mem[m_acc_addr];
            else           m_cpu_data = mem[m_acc_addr];
        end
        exp_cs = m_active && (cyc >= grant_t + 1) && (cyc <= grant_t + 1 + L1);
        exp_cv = m_active && !m_own_dbg && (cyc == done_t);
        exp_dv = m_active &&  m_own_dbg && (cyc == done_t);
        check("romChipSelect", romChipSelect, exp_cs);
        check("romAddress", romAddress, m_rom_addr);
        check("cpuValid", cpuValid, exp_cv);
        check("dbgValid", dbgValid, exp_dv);
        check("cpuData", cpuData, m_cpu_data);
        check("dbgData", dbgData, m_dbg_data);
        $display("[TB] cyc %0d cs=%0b addr=%h cv=%0b cd=%h dv=%0b dd=%h",
                 cyc, romChipSelect, romAddress, cpuValid, cpuData, dbgValid, dbgData);
        cv_prev = cv_last;  cv_last = cpuValid;
        dv_prev = dv_last;  dv_last = dbgValid;
        dv3_prev = dv3_last; dv3_last = dbgValid3;
        if (cpuValid)       begin cv_count++;  cv_cyc = cyc;  end
        if (dbgValid)       begin dv_count++;  dv_cyc = cyc;  end
        if (dbgValid3)      begin dv3_count++; dv3_cyc = cyc; end
        if (romChipSelect3) cs3_count++;
        if (cpuValid3)      cv3_count++;
    endtask

    // Applies the arbitration rules to the inputs present in cycle cyc.
    task automatic model_commit();
        bit dbg_win;
        if (reset) begin
            m_active = 1'b0; t_free = cyc + 1; burst = 0;
            m_cpu_data = '0; m_dbg_data = '0; m_rom_addr = '0;
        end else if (cyc >= t_free) begin
            if (!dbgReq) burst = 0;
            if (cpuReq || dbgReq) begin
                dbg_win    = dbgReq && (!cpuReq || burst >= MAXB);
                m_own_dbg  = dbg_win;
                m_acc_addr = dbg_win ? dbgAddr : cpuAddr;
                m_rom_addr = m_acc_addr;
                m_active   = 1'b1;
                grant_t    = cyc;
                t_free     = cyc + L1 + 3;
                if (dbg_win)     burst = 0;
                else if (dbgReq) burst++;
            end
        end
    endtask

    task automatic tick();
        model_commit();
        @(posedge clk);
        #1;
        cyc++;
        check_outputs();
    endtask

    function automatic logic [14:0] rand_addr();
        if ($urandom_range(0, 7) == 0) return 15'h7FFF;
        return 15'($urandom);
    endfunction

    // Modes: 0 hold, 1 drop after valid, 2 next address after valid, 3 random.
    // Requesters react to the valid seen one cycle earlier, as registered logic would.
    task automatic run(input int n, input int cmode, input int dmode);
        repeat (n) begin
            if (cv_prev) begin
                if (cmode == 1 || cmode == 3) cpuReq = 1'b0;
                if (cmode == 2) cpuAddr = cpuAddr + 15'd1;
            end
            if (cmode == 3 && !cpuReq && $urandom_range(0, 3) == 0) begin
                cpuReq = 1'b1; cpuAddr = rand_addr();
            end
            if (dv_prev) begin
                if (dmode == 1 || dmode == 3) dbgReq = 1'b0;
                if (dmode == 2) dbgAddr = dbgAddr + 15'd1;
            end
            if (dmode == 3 && !dbgReq && $urandom_range(0, 3) == 0) begin
                dbgReq = 1'b1; dbgAddr = rand_addr();
            end
            if (dv3_prev) dbgReq3 = 1'b0;
            tick();
        end
    endtask

    initial begin
        int t0;
        for (int i = 0; i < 32768; i++) mem[i] = 8'($urandom);
        mem[0] = 8'hA9;
        mem[15'h7FFF] = 8'h5C;
        reset = 1'b1;
        cpuReq = 0; dbgReq = 0; cpuAddr = '0; dbgAddr = '0;
        cpuReq3 = 0; dbgReq3 = 0; cpuAddr3 = '0; dbgAddr3 = '0;
        @(posedge clk);
        #1;
        check_outputs();
        run(2, 0, 0);
        reset = 1'b0;
        run(2, 1, 1);

        // Single CPU read of address 0
        cv_count = 0; dv_count = 0;
        cpuReq = 1'b1; cpuAddr = 15'h0000; t0 = cyc;
        run(6, 1, 1);
        check("single_cpu_valid_cycle", cv_cyc - t0, 3);
        check("single_cpu_count", cv_count, 1);
        check("single_cpu_data", cpuData, 8'hA9);
        check("single_cpu_no_dbg", dv_count, 0);

        // Back-to-back CPU reads with request held across RESP
        cv_count = 0;
        cpuReq = 1'b1; cpuAddr = 15'h0010; t0 = cyc;
        run(8, 2, 1);
        check("b2b_count", cv_count, 2);
        check("b2b_second_cycle", cv_cyc - t0, 7);
        cpuReq = 1'b0;
        run(6, 1, 1);

        // Starvation guard with both requests held
        cv_count = 0; dv_count = 0;
        cpuReq = 1'b1; cpuAddr = 15'h0100;
        dbgReq = 1'b1; dbgAddr = 15'h7FFF; t0 = cyc;
        for (int i = 0; i < 40 && dv_count == 0; i++) run(1, 2, 1);
        check("starve_cpu_grants", cv_count, 4);
        check("starve_dbg_cycle", dv_cyc - t0, 19);
        check("starve_dbg_data", dbgData, 8'h5C);
        run(8, 2, 1);
        check("starve_cpu_resumes", cv_count > 4, 1);
        cpuReq = 1'b0;
        run(6, 1, 1);

        // Simultaneous first request
        cv_cyc = -1; dv_cyc = -1;
        cpuReq = 1'b1; cpuAddr = rand_addr();
        dbgReq = 1'b1; dbgAddr = rand_addr(); t0 = cyc;
        run(12, 1, 1);
        check("simul_cpu_first", cv_cyc - t0, 3);
        check("simul_dbg_next", dv_cyc - t0, 7);

        // Reset in the second BUSY cycle aborts, then re-request completes
        cv_count = 0;
        cpuReq = 1'b1; cpuAddr = 15'h7FFF;
        run(2, 0, 0);
        reset = 1'b1;
        run(1, 0, 0);
        reset = 1'b0;
        check("reset_no_valid", cv_count, 0);
        t0 = cyc;
        run(6, 1, 1);
        check("reset_reissue_count", cv_count, 1);
        check("reset_reissue_latency", cv_cyc - t0, 3);

        // READ_LATENCY=3 instance: single debug read
        dv3_count = 0; cs3_count = 0; cv3_count = 0;
        dbgReq3 = 1'b1; dbgAddr3 = 15'h7FFF; t0 = cyc;
        run(9, 1, 1);
        check("lat3_dbg_cycle", dv3_cyc - t0, 5);
        check("lat3_dbg_count", dv3_count, 1);
        check("lat3_dbg_data", dbgData3, 8'h5C);
        check("lat3_cs_cycles", cs3_count, 4);
        check("lat3_no_cpu", cv3_count, 0);

        // Random traffic from both requesters, then drain
        run(3000, 3, 3);
        run(12, 1, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/program_rom_arbiter.md
Name: program_rom_arbiter

Overview:
- Shares the single-port 32 kB program ROM between two read requesters: the CPU instruction-fetch unit and the debug/monitor port.
- Sequences every access: drives the ROM chip select and address, and counts the ROM's synchronous read latency.
- Captures the ROM data bus and returns it to the winning requester with a one-cycle valid pulse.
- Sits between the ROM wrapper and the CPU core/debug unit.

Parameters:
- ADDR_W, 15, ROM address width (32 kB).
- DATA_W, 8, ROM data width.
- READ_LATENCY, 1, clock edges from the ROM sampling the address to its data being valid (1..4).
- MAX_CPU_BURST, 4, consecutive CPU grants allowed while debug is waiting (1..15).

Ports:
- clk, in, 1, system clock.
- reset, in, 1, synchronous, active-high reset.
- cpuReq, in, 1, CPU fetch request; held until cpuValid.
- cpuAddr, in, ADDR_W, CPU fetch address; stable while cpuReq is high.
- cpuValid, out, 1, one-cycle pulse: cpuData holds the fetched byte.
- cpuData, out, DATA_W, registered read data for the CPU.
- dbgReq, in, 1, debug read request; held until dbgValid.
- dbgAddr, in, ADDR_W, debug read address.
- dbgValid, out, 1, one-cycle pulse for debug data.
- dbgData, out, DATA_W, registered read data for debug.
- romChipSelect, out, 1, ROM chip select; high only while an access is in flight.
- romAddress, out, ADDR_W, registered ROM address.
- romData, in, DATA_W, ROM data bus; high-Z when chip select is low.

Behaviour:
- Reset values: all outputs 0; state IDLE; owner CPU; burst counter 0.
- Reset mid-access aborts the access: no valid is issued, and the requester must re-request.
- States: IDLE -> BUSY -> RESP -> IDLE.
- IDLE:
  - With any request pending, pick the winner.
  - Register romAddress from the winner's address, latch the owner, clear the latency counter, go to BUSY.
  - With no request pending, stay in IDLE; romChipSelect stays 0.
- BUSY:
  - romChipSelect = 1 and romAddress is held.
  - Counter increments every cycle.
  - When counter == READ_LATENCY, sample romData into the owner's data register and go to RESP.
  - BUSY therefore lasts READ_LATENCY+1 cycles.
- RESP:
  - The owner's valid = 1 for exactly one cycle; romChipSelect = 0.
  - Requests are ignored in this cycle, so a requester still holding req for the completed access cannot cause a duplicate grant.
  - Next state is IDLE.
- Latency: a request seen in IDLE at cycle 0 produces valid in cycle 2+READ_LATENCY (cycle 3 at the default).
- Throughput: one access per READ_LATENCY+3 cycles.
- Arbitration:
  - CPU wins by default.
  - Burst counter increments on each CPU grant made while dbgReq is high.
  - It clears on any debug grant, and whenever dbgReq is low in IDLE.
  - When the counter reaches MAX_CPU_BURST and dbgReq is high, debug wins the next grant even if cpuReq is high.
  - Simultaneous requests with counter < MAX_CPU_BURST: CPU wins.
- Data registers hold their last value between accesses; the non-owner's data and valid are untouched.
- romData is never sampled outside the BUSY capture cycle (the bus is Z then).
- Address wrap: none; the address passes through unmodified (0x7FFF is legal).
- A requester dropping req during BUSY still receives its valid pulse; the access is not cancelled.

Decomposition:
- Package program_rom_pkg holds:
  - the state enum (IDLE, BUSY, RESP);
  - the owner enum (OWNER_CPU, OWNER_DBG);
  - ROM_ADDR_W = 15 and ROM_DATA_W = 8.
- One natural sub-module: rom_grant_select. It is combinational winner selection plus the registered burst/starvation counter, instantiated once in IDLE decision logic.

Test Plan:
- Single CPU read: cpuReq=1, cpuAddr=0x0000, ROM[0]=0xA9.
  - Expect romChipSelect high in cycles 1-2.
  - Expect cpuValid=1 and cpuData=0xA9 in cycle 3 only; dbgValid stays 0.
- Back-to-back CPU reads: cpuReq held, addresses 0x0010 then 0x0011.
  - Expect valids in cycles 3 and 7.
  - Expect no duplicate access to 0x0010 during RESP.
- Starvation guard: cpuReq and dbgReq held continuously, dbgAddr=0x7FFF (ROM=0x5C).
  - Expect 4 CPU grants, then dbgValid with dbgData=0x5C.
  - CPU resumes afterwards.
- Simultaneous first request: both assert in the same cycle.
  - CPU is served first; debug is served on the next grant once cpuReq is dropped.
- Reset mid-access: assert reset in the second BUSY cycle.
  - Expect outputs 0 next cycle and no cpuValid.
  - A re-issued request completes normally with a 3-cycle latency.
- READ_LATENCY=3 build: a single debug read returns dbgValid in cycle 5 with correct data.
